hamming_secded_rx: RTL and testbench

HAMMING_SECDED_RX -- requirements
Module: hamming_secded_rx

---
 rtl/hamming_secded_rx_pkg.sv | 20 ++
 rtl/hamming_secded_rx_decode.sv | 67 ++++++
 rtl/hamming_secded_rx.sv | 141 ++++++++++++++
 tb/tb_hamming_secded_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_secded_rx_pkg.sv
// Shared definitions for the SECDED serial receiver: code geometry and error class.
package hamming_secded_rx_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        DOUBLE = 2'd2
    } err_class_e;

    // Hamming codeword length for r parity bits.
    function automatic int calc_n(input int r);
        return (1 << r) - 1;
    endfunction

    // Data bits carried by a codeword with r parity bits.
    function automatic int calc_k(input int r);
        return calc_n(r) - r;
    endfunction

endpackage

// File: rtl/hamming_secded_rx_decode.sv
// Combinational SECDED decode of one frame: syndrome, overall parity,
// single-bit correction and data extraction.
// Frame layout: frame[F-1] is codeword position 1, frame[1] is position N,
// frame[0] is the overall parity bit p0.
module secded_decode
    import hamming_secded_rx_pkg::*;
#(
    parameter  int R = 3,
    localparam int N = calc_n(R),
    localparam int K = calc_k(R),
    localparam int F = N + 1
) (
    input  logic [F-1:0] frame,
    output logic [K-1:0] data,
    output logic [R-1:0] syndrome,
    output err_class_e   err_class
);

    logic [N:1] cw;
    logic       parity;
    logic       flip;

    // Re-index the frame by codeword position.
    always_comb begin
        cw = '0;
        for (int i = 1; i <= N; i++) begin
            cw[i] = frame[F-i];
        end
    end

    // Syndrome is the XOR of the indices of all set positions; parity covers p0 too.
    always_comb begin
        syndrome = '0;
        for (int i = 1; i <= N; i++) begin
            if (cw[i]) begin
                syndrome = syndrome ^ R'(i);
            end
        end
        parity = ^frame;
    end

    // Classify; a nonzero syndrome with even parity means two errors, left uncorrected.
    always_comb begin
        flip      = 1'b0;
        err_class = NONE;
        if (parity) begin
            err_class = SINGLE;
            flip      = (syndrome != '0);
        end else if (syndrome != '0) begin
            err_class = DOUBLE;
        end
    end

    // Gather non-power-of-two positions MSB-first, applying the correction on the way.
    always_comb begin
        int j;
        j    = K - 1;
        data = '0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                data[j] = cw[i] ^ (flip && (syndrome == R'(i)));
                j--;
            end
        end
    end

endmodule

// File: rtl/hamming_secded_rx.sv
// Serial SECDED receiver: deserialises frames, decodes them, and presents
// corrected words through a valid/ready output with one frame of buffering
// in front of the output register, plus saturating error counters.
module hamming_secded_rx
    import hamming_secded_rx_pkg::*;
#(
    parameter  int R  = 3,
    parameter  int CW = 16,
    localparam int N  = calc_n(R),
    localparam int K  = calc_k(R),
    localparam int F  = N + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_in,
    input  logic          strobe_in,
    input  logic          out_ready,
    input  logic          cnt_clr,
    output logic [K-1:0]  data_out,
    output logic          out_valid,
    output logic [R-1:0]  syndrome,
    output logic          err_single,
    output logic          err_double,
    output logic          overrun,
    output logic [CW-1:0] corr_cnt,
    output logic [CW-1:0] uncorr_cnt
);

    localparam int BW = $clog2(F);

    logic [BW-1:0] bit_cnt;
    logic [F-2:0]  shift_q;
    logic [F-1:0]  frame_q;
    logic          frame_vld;
    logic          last_bit;

    logic [K-1:0]  dec_data, res_data;
    logic [R-1:0]  dec_syn, res_syn;
    err_class_e    dec_cls, res_cls;
    logic          res_vld;

    logic          res_to_out;
    logic          res_free;
    logic          drop;

    assign last_bit   = (bit_cnt == BW'(F - 1));
    // The pending result moves on when the output is empty or handing its word over now.
    assign res_to_out = res_vld & (~out_valid | out_ready);
    assign res_free   = ~res_vld | res_to_out;
    assign drop       = frame_vld & ~res_free;

    // Shift in strobed bits; the counter wraps as the last frame bit arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (strobe_in) begin
            shift_q <= {shift_q[F-3:0], data_in};
            bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
        end
    end

    // Capture the complete frame (including the bit arriving now) for decoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q   <= '0;
            frame_vld <= 1'b0;
        end else begin
            frame_vld <= strobe_in & last_bit;
            if (strobe_in && last_bit) begin
                frame_q <= {shift_q, data_in};
            end
        end
    end

    secded_decode #(.R(R)) u_decode (
        .frame     (frame_q),
        .data      (dec_data),
        .syndrome  (dec_syn),
        .err_class (dec_cls)
    );

    // Result buffer: holds one decoded frame while the output register is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld  <= 1'b0;
            res_data <= '0;
            res_syn  <= '0;
            res_cls  <= NONE;
        end else if (frame_vld && res_free) begin
            res_vld  <= 1'b1;
            res_data <= dec_data;
            res_syn  <= dec_syn;
            res_cls  <= dec_cls;
        end else if (res_to_out) begin
            res_vld  <= 1'b0;
        end
    end

    // Output register with valid/ready handover; overrun flags a frame dropped this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            syndrome   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= drop;
            if (res_to_out) begin
                out_valid  <= 1'b1;
                data_out   <= res_data;
                syndrome   <= res_syn;
                err_single <= (res_cls == SINGLE);
                err_double <= (res_cls == DOUBLE);
            end else if (out_valid && out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

    // Saturating error counters; clear wins over any increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (res_to_out && res_cls == SINGLE && corr_cnt != {CW{1'b1}}) begin
                corr_cnt <= corr_cnt + CW'(1);
            end
            if ((drop || (res_to_out && res_cls == DOUBLE)) && uncorr_cnt != {CW{1'b1}}) begin
                uncorr_cnt <= uncorr_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_rx.sv
// Self-checking bench for hamming_secded_rx (R=3, 4-bit counters for saturation).
module tb_hamming_secded_rx;

    localparam int R      = 3;
    localparam int CW     = 4;
    localparam int N      = 7;
    localparam int K      = 4;
    localparam int F      = 8;
    localparam int CNTMAX = 15;

    // Serial stream 0,1,1,0,0,1,1,0 (bit i is sent i-th) for data 1011.
    localparam logic [F-1:0] CLEAN = 8'b0110_0110;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_in;
    logic          strobe_in;
    logic          out_ready;
    logic          cnt_clr;
    logic [K-1:0]  data_out;
    logic          out_valid;
    logic [R-1:0]  syndrome;
    logic          err_single;
    logic          err_double;
    logic          overrun;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    logic rnd_mode  = 1'b0;
    logic rr        = 1'b1;
    logic fixed_rdy = 1'b1;
    assign out_ready = rnd_mode ? rr : fixed_rdy;

    hamming_secded_rx #(.R(R), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .out_ready  (out_ready),
        .cnt_clr    (cnt_clr),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .syndrome   (syndrome),
        .err_single (err_single),
        .err_double (err_double),
        .overrun    (overrun),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [K-1:0] d;
        logic [R-1:0] s;
        logic         se;
        logic         de;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   ov_cnt     = 0;
    int   exp_corr   = 0;
    int   exp_uncorr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNTMAX) ? CNTMAX : v;
    endfunction

    // Bit i of a frame vector is codeword position i+1; bit F-1 is p0.
    function automatic logic [F-1:0] encode(input logic [K-1:0] d);
        logic [F-1:0] fv;
        int j;
        int s;
        fv = '0;
        j  = K - 1;
        s  = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                fv[pos-1] = d[j];
                if (d[j]) s = s ^ pos;
                j--;
            end
        end
        for (int b = 0; b < R; b++) fv[(1 << b) - 1] = s[b];
        fv[F-1] = ^fv[F-2:0];
        return fv;
    endfunction

    function automatic exp_t model(input logic [F-1:0] fv);
        exp_t e;
        logic [F-1:0] c;
        int s;
        int j;
        logic p;
        c = fv;
        s = 0;
        p = ^fv;
        for (int pos = 1; pos <= N; pos++) if (fv[pos-1]) s = s ^ pos;
        if (s != 0 && p) c[s-1] = ~c[s-1];
        e.d = '0;
        j = K - 1;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                e.d[j] = c[pos-1];
                j--;
            end
        end
        e.s  = s[R-1:0];
        e.se = p;
        e.de = (s != 0) && !p;
        return e;
    endfunction

    task automatic push_const(input logic [K-1:0] d, input logic [R-1:0] s, input logic se, input logic de);
        exp_t e;
        e.d = d; e.s = s; e.se = se; e.de = de;
        exp_q.push_back(e);
        if (se) exp_corr = sat(exp_corr + 1);
        if (de) exp_uncorr = sat(exp_uncorr + 1);
    endtask

    task automatic push_model(input logic [F-1:0] fv);
        exp_t e;
        e = model(fv);
        push_const(e.d, e.s, e.se, e.de);
    endtask

    task automatic send(input logic [F-1:0] fv, input int gap);
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            data_in   = fv[i];
            strobe_in = 1'b1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                strobe_in = 1'b0;
                data_in   = 1'($urandom);
            end
        end
        @(negedge clk);
        strobe_in = 1'b0;
        data_in   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every word handed over is compared against the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (overrun === 1'b1) ov_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out",   32'(data_out),   32'(e.d));
                    chk("syndrome",   32'(syndrome),   32'(e.s));
                    chk("err_single", 32'(err_single), 32'(e.se));
                    chk("err_double", 32'(err_double), 32'(e.de));
                end
            end
        end
    end

    // Random consumer: never stalls for more than three cycles in a row.
    initial begin
        int lows;
        lows = 0;
        forever begin
            @(negedge clk);
            if (lows >= 3) begin
                rr   = 1'b1;
                lows = 0;
            end else begin
                rr   = 1'($urandom_range(0, 1));
                lows = rr ? 0 : lows + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [F-1:0] fv;
        logic [F-1:0] f2, f3;
        int ov_before;
        int kind, a, b;

        rst       = 1'b1;
        data_in   = 1'b0;
        strobe_in = 1'b0;
        cnt_clr   = 1'b0;
        fixed_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_data_out",   32'(data_out),   32'd0);
        chk("rst_syndrome",   32'(syndrome),   32'd0);
        chk("rst_err_single", 32'(err_single), 32'd0);
        chk("rst_err_double", 32'(err_double), 32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        chk("rst_corr_cnt",   32'(corr_cnt),   32'd0);
        chk("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        rst = 1'b0;

        // Clean frame with latency check.
        push_const(4'b1011, 3'b000, 1'b0, 1'b0);
        send(CLEAN, 0);
        chk("lat_after_t",  32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_after_t1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_after_t2", 32'(out_valid), 32'd1);
        drain("drain_clean");

        // Position 5 flipped.
        push_const(4'b1011, 3'b101, 1'b1, 1'b0);
        send(CLEAN ^ 8'b0001_0000, 0);
        drain("drain_pos5");
        chk("corr_after_pos5", 32'(corr_cnt), 32'd1);

        // Positions 3 and 6 flipped.
        push_const(4'b0001, 3'b101, 1'b0, 1'b1);
        send(CLEAN ^ 8'b0010_0100, 0);
        drain("drain_pos36");
        chk("uncorr_after_pos36", 32'(uncorr_cnt), 32'd1);

        // p0 flipped.
        push_const(4'b1011, 3'b000, 1'b1, 1'b0);
        send(CLEAN ^ 8'b1000_0000, 0);
        drain("drain_p0");
        chk("corr_after_p0", 32'(corr_cnt), 32'd2);

        // Reset mid-frame, then a gapped clean frame.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_in   = 1'($urandom);
            strobe_in = 1'b1;
        end
        @(negedge clk);
        strobe_in = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        exp_corr   = 0;
        exp_uncorr = 0;
        chk("midrst_corr",   32'(corr_cnt),   32'd0);
        chk("midrst_uncorr", 32'(uncorr_cnt), 32'd0);
        push_const(4'b1011, 3'b000, 1'b0, 1'b0);
        send(CLEAN, 3);
        drain("drain_gapped");

        // Stalled consumer across three frames: third frame is dropped.
        fixed_rdy = 1'b0;
        f2 = encode(4'b0110);
        f3 = encode(4'b1100);
        ov_before = ov_cnt;
        push_model(CLEAN);
        push_model(f2);
        send(CLEAN, 0);
        send(f2, 0);
        send(f3, 0);
        exp_uncorr = sat(exp_uncorr + 1);
        repeat (4) @(negedge clk);
        chk("stall_data_held",  32'(data_out),          32'h0000000b);
        chk("stall_valid_held", 32'(out_valid),         32'd1);
        chk("stall_overrun",    32'(ov_cnt - ov_before), 32'd1);
        chk("stall_uncorr",     32'(uncorr_cnt),        32'(exp_uncorr));
        fixed_rdy = 1'b1;
        drain("drain_stall");

        // Randomized frames with random consumer back-pressure.
        ov_before = ov_cnt;
        rnd_mode  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            fv   = encode(4'($urandom));
            kind = $urandom_range(0, 2);
            a    = $urandom_range(0, F - 1);
            b    = (a + $urandom_range(1, F - 1)) % F;
            if (kind >= 1) fv[a] = ~fv[a];
            if (kind == 2) fv[b] = ~fv[b];
            push_model(fv);
            send(fv, $urandom_range(0, 2));
        end
        drain("drain_random");
        rnd_mode = 1'b0;
        chk("rand_corr",    32'(corr_cnt),           32'(exp_corr));
        chk("rand_uncorr",  32'(uncorr_cnt),         32'(exp_uncorr));
        chk("rand_overrun", 32'(ov_cnt - ov_before), 32'd0);

        // Counter clear, then saturation of the uncorrectable counter.
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr    = 1'b0;
        exp_corr   = 0;
        exp_uncorr = 0;
        chk("clr_corr",   32'(corr_cnt),   32'd0);
        chk("clr_uncorr", 32'(uncorr_cnt), 32'd0);
        for (int n = 0; n < 17; n++) begin
            fv = encode(4'($urandom)) ^ 8'b0000_0011;
            push_model(fv);
            send(fv, 0);
        end
        drain("drain_sat");
        chk("sat_uncorr", 32'(uncorr_cnt), 32'(CNTMAX));

        // Clear held through a counted load: clear wins.
        cnt_clr = 1'b1;
        push_model(CLEAN ^ 8'b0000_0100);
        send(CLEAN ^ 8'b0000_0100, 0);
        drain("drain_clrprio");
        cnt_clr    = 1'b0;
        exp_corr   = 0;
        exp_uncorr = 0;
        @(negedge clk);
        chk("clrprio_corr",   32'(corr_cnt),   32'(exp_corr));
        chk("clrprio_uncorr", 32'(uncorr_cnt), 32'(exp_uncorr));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
